gpio_bcd_display: RTL
=====================

Name: gpio_bcd_display

Overview:
- Reader-side peripheral for the CPU's 32-bit `gpio_out` CSR port (io2/io3).
- Takes the unsigned binary value the CPU writes and converts it to 8 decimal digits with a sequential shift-add-3 (double-dabble) engine.
- Drives eight active-low seven-segment displays with the decimal value.
- Sits in top level between the `cpu` instance and the `HEX0`..`HEX7` pins, on `CLOCK_50`.

Parameters:
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all 8 digits.
- OVF_DASH, 1, 1 = show all dashes when value exceeds 99,999,999; 0 = show the low 8 digits.

Ports:
- clk  input  1  system clock (`CLOCK_50`)
- rst  input  1  asynchronous reset, active-low (asserted when rst==0)
- value_in  input  32  unsigned binary value, connected to cpu `gpio_out`
- hex0..hex7  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = least significant digit
- busy  output  1  conversion in progress
- ovf  output  1  registered; last displayed value > 99,999,999

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst==0 clears everything immediately, independent of clk).
  - State = IDLE, shown_val = 0, busy = 0, ovf = 0.
  - BLANK_LEADING=1: hex0 = 1000000 ("0"), hex1..hex7 = 1111111 (blank).
  - BLANK_LEADING=0: all hex outputs = 1000000.
- Internal registers: shift register (32 bits), BCD accumulator (40 bits, 10 digits), 5-bit iteration counter, shown_val (32 bits), snapshot (32 bits).
- State IDLE:
  - If value_in != shown_val at a rising edge: snapshot <= value_in, load shift register, clear BCD, counter <= 0, go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT, one iteration per cycle:
  - Add 3 to every BCD nibble >= 5.
  - Shift {BCD, shift register} left by 1.
  - counter++.
  - Leave to DONE on the edge performing iteration 32 (counter == 31).
- State DONE, one cycle:
  - Register the segment outputs and ovf from the final BCD.
  - shown_val <= snapshot.
  - Go to IDLE.
- busy = (state != IDLE), combinational from the state register.
- Latency: the hex outputs and ovf change on exactly the 34th rising edge after the IDLE edge that detected the mismatch (1 load + 32 shifts + 1 DONE).
- value_in changes during SHIFT/DONE are ignored; there is no abort or restart.
  - After returning to IDLE, the next edge re-compares value_in with shown_val and starts a new conversion if they differ.
  - The final value is therefore always displayed; intermediate values may be skipped.
- Overflow: ovf = 1 when BCD digit 8 or digit 9 is nonzero.
  - OVF_DASH=1 and ovf: all hex = 0111111.
  - OVF_DASH=0 and ovf: low 8 digits are shown; blanking is disabled.
- Leading blanking (BLANK_LEADING=1, no overflow): digit i (i >= 1) = 1111111 if digits i..7 are all 0. hex0 is never blanked.
- Digit encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Every hex output is registered; no combinational path from value_in to hex.
- Boundary values:
  - value_in = 0 after reset: no conversion (matches shown_val).
  - 32'hFFFFFFFF (4,294,967,295): converts correctly; ovf = 1.

Test Plan:
1. Assert rst=0 then release with value_in=0 -> hex0=1000000, hex1..7=1111111, busy=0, ovf=0; busy stays 0 for 100 cycles.
2. value_in=12345678 held -> busy=1 from the edge after detection for 33 cycles; on edge 34, hex7..hex0 = 1,2,3,4,5,6,7,8 patterns, busy=0, ovf=0.
3. value_in=42 -> hex1=0011001, hex0=0100100, hex7..hex2=1111111; same value with BLANK_LEADING=0 -> hex7..hex2=1000000.
4. value_in=99999999 -> all digits 0010000, ovf=0; then value_in=100000000 -> all hex=0111111, ovf=1; with OVF_DASH=0 -> hex7..hex0 all 1000000, ovf=1.
5. value_in=111, changed to 222 on cycle 10 of the conversion -> display shows 111 at edge 34; busy re-asserts on the next edge; 222 is displayed 34 edges after that.
6. value_in=4294967295 with rst pulsed low mid-SHIFT (cycle 15) -> outputs immediately at reset values; after release, converts, ovf=1, all dashes.

Source files
------------

// File: rtl/gpio_bcd_display.sv
// gpio_bcd_display
//   Converts the 32-bit unsigned value written by the CPU to 8 decimal digits
//   using a sequential shift-add-3 (double-dabble) engine. The digits drive
//   eight active-low seven-segment displays.
//
// Parameters
//   BLANK_LEADING : 1 = blank leading zero digits (hex0 always shown)
//   OVF_DASH      : 1 = show dashes on every display when value > 99,999,999
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   value_in   unsigned binary value from the CPU gpio_out CSR
//   hex0..hex7 active-low segments {g,f,e,d,c,b,a}, hex0 = least significant
//   busy       conversion in progress
//   ovf        last displayed value exceeded 99,999,999
module gpio_bcd_display #(
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit OVF_DASH      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic        busy,
  output logic        ovf
);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] shift_q;
  logic [39:0] bcd_q;
  logic [39:0] bcd_adj;
  logic [4:0]  cnt_q;
  logic [31:0] shown_val;
  logic [31:0] snapshot;

  logic [6:0]  hex_q   [8];
  logic [6:0]  hex_nxt [8];
  logic        ovf_nxt;

  // Add 3 to every BCD nibble >= 5 ahead of the shift.
  function automatic logic [39:0] add3_all(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low seven-segment encoding, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign bcd_adj = add3_all(bcd_q);
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (value_in != shown_val) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Segment patterns derived from the finished BCD accumulator. Digits 8 and
  // 9 only ever hold a nonzero value when the input exceeds eight digits.
  always_comb begin
    logic zero_above;
    ovf_nxt    = |bcd_q[39:32];
    zero_above = 1'b1;
    for (int i = 0; i < 8; i++) hex_nxt[i] = SEG_ZERO;
    for (int i = 7; i >= 0; i--) begin
      zero_above = zero_above & (bcd_q[4*i +: 4] == 4'd0);
      if (ovf_nxt && OVF_DASH)
        hex_nxt[i] = SEG_DASH;
      else if (BLANK_LEADING && !ovf_nxt && (i != 0) && zero_above)
        hex_nxt[i] = SEG_BLANK;
      else
        hex_nxt[i] = seg7(bcd_q[4*i +: 4]);
    end
  end

  // Conversion engine and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      shown_val <= '0;
      snapshot  <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < 8; i++)
        hex_q[i] <= ((i == 0) || !BLANK_LEADING) ? SEG_ZERO : SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (value_in != shown_val) begin
            snapshot <= value_in;
            shift_q  <= value_in;
            bcd_q    <= '0;
            cnt_q    <= '0;
          end
        end
        SHIFT: begin
          bcd_q   <= (bcd_adj << 1) | {39'd0, shift_q[31]};
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 5'd1;
        end
        DONE: begin
          for (int i = 0; i < 8; i++) hex_q[i] <= hex_nxt[i];
          ovf       <= ovf_nxt;
          shown_val <= snapshot;
        end
        default: ;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule
